// File: rtl/key_mode_sequencer_if.sv
// -----------------------------------------------------------------------------
// key_mode_sequencer_if
// Groups the pushbutton input and the mode outputs of key_mode_sequencer.
//   Key1       : raw pushbutton, active low, asynchronous to the clock
//   mode       : current ALU mode, binary
//   modeLEDs   : one-hot copy of mode
//   modeStrobe : one-cycle pulse whenever mode takes a new value
//   longPress  : one-cycle pulse when a long press is recognised
// slave  : the sequencer side (drives the mode outputs)
// master : the board / environment side (drives Key1)
// -----------------------------------------------------------------------------
interface key_mode_sequencer_if #(
   parameter int NUM_MODES = 4
);
   localparam int MODE_W = $clog2(NUM_MODES);

   logic                 Key1;
   logic [MODE_W-1:0]    mode;
   logic [NUM_MODES-1:0] modeLEDs;
   logic                 modeStrobe;
   logic                 longPress;

   modport master (
      output Key1,
      input  mode,
      input  modeLEDs,
      input  modeStrobe,
      input  longPress
   );

   modport slave (
      input  Key1,
      output mode,
      output modeLEDs,
      output modeStrobe,
      output longPress
   );
endinterface

// File: rtl/key_mode_sequencer.sv
// -----------------------------------------------------------------------------
// key_mode_sequencer
// Synchronises and debounces the active-low Key1 pushbutton and advances a
// wrapping ALU mode counter once per clean press. Holding the key for
// LONG_PRESS_CYCLES after the press is accepted forces mode 0 (once per press).
// Ports:
//   clk_50MHz : system clock, rising edge
//   resetN    : asynchronous active-low reset
//   kif       : slave modport carrying Key1, mode, modeLEDs, modeStrobe,
//               longPress (all outputs registered)
// -----------------------------------------------------------------------------
module key_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 100000000,
   parameter int NUM_MODES         = 4
) (
   input  logic                  clk_50MHz,
   input  logic                  resetN,
   key_mode_sequencer_if.slave   kif
);

   localparam int MODE_W  = $clog2(NUM_MODES);
   localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  DB_C      = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  LP_C      = CNT_W'(LONG_PRESS_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   // Wrapping advance; values >= NUM_MODES are never produced.
   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
      if (m == LAST_MODE) begin
         next_mode = {MODE_W{1'b0}};
      end else begin
         next_mode = m + MODE_W'(1);
      end
   endfunction

   // One-hot decode of a mode value.
   function automatic logic [NUM_MODES-1:0] one_hot(input logic [MODE_W-1:0] m);
      for (int i = 0; i < NUM_MODES; i++) begin
         one_hot[i] = (m == MODE_W'(i));
      end
   endfunction

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [MODE_W-1:0]    mode_q, mode_d;
   logic [NUM_MODES-1:0] leds_q, leds_d;
   logic                 strobe_q, strobe_d;
   logic                 long_q, long_d;
   logic                 fired_q, fired_d;   // long press already taken for this press
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 key_sync;

   assign key_sync = sync2_q;

   // Next-state logic: synchroniser, debounce FSM, mode counter and strobes.
   always_comb begin
      sync1_d  = kif.Key1;
      sync2_d  = sync1_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      fired_d  = fired_q;
      strobe_d = 1'b0;
      long_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!key_sync) begin
               state_d = PRESS_DB;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         PRESS_DB: begin
            if (key_sync) begin
               // glitch: back to idle with no visible effect
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == DB_C) begin
               state_d  = HELD;
               cnt_d    = {CNT_W{1'b0}};
               mode_d   = next_mode(mode_q);
               strobe_d = 1'b1;
               fired_d  = 1'b0;
            end else begin
               cnt_d    = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (key_sync) begin
               state_d = REL_DB;
               cnt_d   = CNT_ONE;
            end else if (cnt_q < LP_C) begin
               cnt_d = cnt_q + CNT_ONE;
               // fired_q keeps a release bounce from re-arming the long press
               if ((cnt_q + CNT_ONE == LP_C) && !fired_q) begin
                  mode_d   = {MODE_W{1'b0}};
                  strobe_d = 1'b1;
                  long_d   = 1'b1;
                  fired_d  = 1'b1;
               end else begin
                  fired_d  = fired_q;
               end
            end else begin
               cnt_d = cnt_q;   // saturated
            end
         end
         REL_DB: begin
            if (!key_sync) begin
               // release was bounce; counter intentionally not restored
               state_d = HELD;
            end else if (cnt_q == DB_C) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      leds_d = one_hot(mode_d);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_50MHz or negedge resetN) begin
      if (!resetN) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         mode_q   <= {MODE_W{1'b0}};
         leds_q   <= {{(NUM_MODES-1){1'b0}}, 1'b1};
         strobe_q <= 1'b0;
         long_q   <= 1'b0;
         fired_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         leds_q   <= leds_d;
         strobe_q <= strobe_d;
         long_q   <= long_d;
         fired_q  <= fired_d;
      end
   end

   assign kif.mode       = mode_q;
   assign kif.modeLEDs   = leds_q;
   assign kif.modeStrobe = strobe_q;
   assign kif.longPress  = long_q;

endmodule
